// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D cache fill arbiter and its beat counters.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    WRITE   = 2'd3
  } arb_state_t;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_MEM_LATENCY    = 4;
  localparam int ADDR_W             = 16;
  localparam int DATA_W             = 16;

  // One spare bit so a counter can hold the full line count without wrapping.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/grant/return signals plus the memory port of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_service;
  logic              d_service;
  logic              i_valid;
  logic              d_valid;
  logic [DATA_W-1:0] rdata;
  logic              wr_done;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
    output i_service, d_service, i_valid, d_valid, rdata, wr_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
    input  i_service, d_service, i_valid, d_valid, rdata, wr_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_beat_counter.sv
// Saturating up-counter with synchronous clear; o_done when the count reaches LIMIT.
module arb_beat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_WORDS_PER_LINE,
  parameter int CNT_W = cnt_width(LIMIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache line fills and D write-throughs onto one memory port.
// Grant is one cycle after the IDLE decision; losing requesters simply wait (level requests).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int MEM_LATENCY    = DEF_MEM_LATENCY
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W     = cnt_width(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_last_d;
  logic             w_last_d_nxt;
  logic             r_i_service;
  logic             r_d_service;
  logic             w_serve_i;
  logic             w_serve_d;
  logic             w_serve;
  logic             w_write;
  logic             w_cnt_clr;
  logic             w_issue_inc;
  logic             w_beat_inc;
  logic             w_beat_last;
  logic             w_issue_done;
  logic             w_beat_done;
  logic [CNT_W-1:0] w_issue_cnt;
  logic [CNT_W-1:0] w_beat_cnt;

  assign w_serve_i   = (r_state == SERVE_I);
  assign w_serve_d   = (r_state == SERVE_D);
  assign w_serve     = w_serve_i || w_serve_d;
  assign w_write     = (r_state == WRITE);
  assign w_issue_inc = w_serve && !w_issue_done;
  assign w_beat_inc  = w_serve && bus.mem_valid;
  assign w_beat_last = w_beat_inc && (w_beat_cnt == LAST_BEAT);
  assign w_cnt_clr   = (w_state_nxt == IDLE);

  arb_beat_counter #(.LIMIT(WORDS_PER_LINE), .CNT_W(CNT_W)) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_issue_inc),
    .o_count (w_issue_cnt),
    .o_done  (w_issue_done)
  );

  arb_beat_counter #(.LIMIT(WORDS_PER_LINE), .CNT_W(CNT_W)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_beat_inc),
    .o_count (w_beat_cnt),
    .o_done  (w_beat_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_i_service <= 1'b0;
      r_d_service <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_d    <= w_last_d_nxt;
      r_i_service <= (w_state_nxt == SERVE_I);
      r_d_service <= (w_state_nxt == SERVE_D);
    end
  end

  // Stores bypass fills; colliding misses go to whichever cache was not served last.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    case (r_state)
      IDLE: begin
        if (bus.d_wr) begin
          w_state_nxt = WRITE;
        end else if (bus.i_req && bus.d_req) begin
          w_state_nxt = r_last_d ? SERVE_I : SERVE_D;
        end else if (bus.d_req) begin
          w_state_nxt = SERVE_D;
        end else if (bus.i_req) begin
          w_state_nxt = SERVE_I;
        end
      end
      SERVE_I: begin
        if (w_beat_last) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b0;
        end
      end
      SERVE_D: begin
        if (w_beat_last) begin
          w_state_nxt  = IDLE;
          w_last_d_nxt = 1'b1;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = w_issue_inc || w_write;
    bus.mem_wr    = w_write;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.wr_done   = w_write;
    bus.i_valid   = w_serve_i && bus.mem_valid;
    bus.d_valid   = w_serve_d && bus.mem_valid;
    bus.rdata     = '0;
    if (w_serve_i) begin
      bus.mem_addr = bus.i_addr;
    end else if (w_serve_d || w_write) begin
      bus.mem_addr = bus.d_addr;
    end
    if (w_write) begin
      bus.mem_wdata = bus.d_wdata;
    end
    if (w_beat_inc) begin
      bus.rdata = bus.mem_rdata;
    end
  end

  assign bus.i_service = r_i_service;
  assign bus.d_service = r_d_service;

  // A fixed-latency memory returns each beat exactly MEM_LATENCY cycles after its issue.
  a_beat_has_issue: assert property (@(posedge clk) disable iff (rst)
    w_beat_inc |-> $past(w_issue_inc, MEM_LATENCY));

  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    (w_beat_cnt <= w_issue_cnt) && !w_beat_done);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 8: 16-bit beats per cache-line fill.
REQ-002 SHALL have parameter MEM_LATENCY, default 4: cycles from mem_en to mem_valid.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req in 1 (I-cache miss) and i_addr in 16 (I-cache fill address, stepped by the cache FSM).
REQ-006 SHALL have ports d_req in 1 (D-cache miss), d_addr in 16, d_wr in 1 (write-through store request), d_wdata in 16.
REQ-007 SHALL have ports i_service out 1 and d_service out 1: grant to the cache fill FSM.
REQ-008 SHALL have ports i_valid out 1, d_valid out 1, rdata out 16: fill beat return.
REQ-009 SHALL have port wr_done out 1: one-cycle pulse, store accepted.
REQ-010 SHALL have ports mem_en out 1, mem_wr out 1, mem_addr out 16, mem_wdata out 16, mem_rdata in 16, mem_valid in 1.

Function
REQ-011 SHALL implement states IDLE, SERVE_I, SERVE_D, WRITE.
REQ-012 IDLE priority SHALL be: d_wr first, then misses round-robin via a last-served flag (fresh reset favours D).
REQ-013 IDLE->WRITE on d_wr; WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, wr_done=1; then IDLE.
REQ-014 IDLE->SERVE_x on grant; x_service SHALL be 1 for every cycle in SERVE_x, registered (asserted the cycle after entry decision).
REQ-015 In SERVE_x, mem_addr SHALL equal x_addr combinationally; mem_en=1, mem_wr=0 while issued-count < WORDS_PER_LINE.
REQ-016 Issued-count SHALL increment per cycle mem_en=1; beat-count SHALL increment per mem_valid.
REQ-017 Each mem_valid in SERVE_x SHALL drive rdata=mem_rdata and x_valid=1 the same cycle; other cache's valid SHALL stay 0.
REQ-018 On the WORDS_PER_LINE-th mem_valid SHALL return to IDLE and update last-served to x; x_service drops next cycle.
REQ-019 Fill SHALL take WORDS_PER_LINE+MEM_LATENCY cycles (12 default) from service assertion to final beat.
REQ-020 Requests arriving outside IDLE SHALL be held off (no grant, no wr_done) and served later; requests are level, not latched.
REQ-021 mem_valid in IDLE or WRITE SHALL be ignored: no valid outputs.
REQ-022 Counters SHALL be $clog2(WORDS_PER_LINE)+1 bits and clear on every IDLE entry; no wrap inside a fill.
REQ-023 A request dropping mid-SERVE SHALL not abort the fill; the full line is still returned.
REQ-024 Outside active states all memory-side outputs SHALL be 0.

Reset
REQ-025 rst SHALL asynchronously force IDLE, counters 0, last-served=I (so D wins first), all outputs 0.
REQ-026 Reset mid-fill SHALL discard in-flight beats; late mem_valid after release SHALL be ignored per REQ-021.

Structure
REQ-027 State enum and default WORDS_PER_LINE/MEM_LATENCY constants SHALL live in the shared storage package.
REQ-028 Issue/beat counting SHALL be one sub-module, arb_beat_counter (count, clear, done at parameter limit), instanced twice.

Verification
REQ-029 I miss alone, addr 0x1230..0x123E -> i_service, 8 i_valid beats cycles 5..12, rdata = memory words, d_valid never 1.
REQ-030 i_req and d_req same cycle after reset -> D served first, then I; last-served alternates on repeat collisions.
REQ-031 d_wr=1, addr 0x0040, data 0xBEEF during I fill -> held; after fill one WRITE cycle, wr_done pulse, memory[0x0040]=0xBEEF.
REQ-032 d_wr and d_req together in IDLE -> WRITE first, then SERVE_D.
REQ-033 rst asserted at beat 3 of D fill -> outputs 0 immediately, stale mem_valid ignored, next i_req served normally.
